// File: rtl/qam_mod_stream.sv
// qam_mod_stream: streaming QAM modulator.
// Accepts one symbol per valid/ready handshake, holds it for SAMPLES_PER_SYM
// samples and mixes its odd-integer I/Q levels onto an NCO carrier:
//   sample = L_I*cos - L_Q*sin
// Optional feature macro: QAM_MOD_GRAY_EN (Gray-decode each axis code before
// level mapping; natural binary when undefined).
module qam_mod_stream #(
  parameter int BITS_PER_SYM    = 4,
  parameter int WAVE_WIDTH      = 16,
  parameter int PHASE_WIDTH     = 16,
  parameter int LUT_ADDR_W      = 6,
  parameter int SAMPLES_PER_SYM = 4,
  localparam int OUT_WIDTH      = WAVE_WIDTH + BITS_PER_SYM / 2 + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PHASE_WIDTH-1:0]      freq_word,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BITS_PER_SYM-1:0]     data_in,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] sample_out,
  output logic                        underrun
);

  localparam int M        = BITS_PER_SYM / 2;
  localparam int LUT_SIZE = 1 << LUT_ADDR_W;
  localparam int CNT_W    = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_PER_SYM - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Round a real carrier value to the nearest integer, halves away from zero.
  function automatic logic signed [WAVE_WIDTH-1:0] round_wave(input real v);
    if (v >= 0.0) return WAVE_WIDTH'($rtoi(v + 0.5));
    else          return WAVE_WIDTH'(-$rtoi(0.5 - v));
  endfunction

  // Full-cycle carrier table, packed entry a at bits [a*WAVE_WIDTH +: WAVE_WIDTH].
  function automatic logic [LUT_SIZE*WAVE_WIDTH-1:0] build_table(input bit want_sin);
    logic [LUT_SIZE*WAVE_WIDTH-1:0] t;
    real amp;
    real ang;
    t   = '0;
    amp = real'((1 << (WAVE_WIDTH - 1)) - 1);
    for (int a = 0; a < LUT_SIZE; a++) begin
      ang = 2.0 * 3.14159265358979323846 * real'(a) / real'(LUT_SIZE);
      t[a*WAVE_WIDTH +: WAVE_WIDTH] = round_wave(amp * (want_sin ? $sin(ang) : $cos(ang)));
    end
    return t;
  endfunction

  localparam logic [LUT_SIZE*WAVE_WIDTH-1:0] COS_TBL = build_table(1'b0);
  localparam logic [LUT_SIZE*WAVE_WIDTH-1:0] SIN_TBL = build_table(1'b1);

  // Axis code to odd level 2*c - (2^M - 1).
  function automatic logic signed [M:0] axis_level(input logic [M-1:0] code);
    logic [M-1:0]        c;
    logic signed [M+1:0] t;
`ifdef QAM_MOD_GRAY_EN
    c[M-1] = code[M-1];
    for (int i = M - 2; i >= 0; i--) c[i] = c[i+1] ^ code[i];
`else
    c = code;
`endif
    t = $signed({1'b0, c, 1'b0}) - $signed((M + 2)'((1 << M) - 1));
    return t[M:0];
  endfunction

  // Full-precision mix; the difference always fits OUT_WIDTH.
  function automatic logic signed [OUT_WIDTH-1:0] mix(
    input logic signed [M:0]            li,
    input logic signed [M:0]            lq,
    input logic signed [WAVE_WIDTH-1:0] c,
    input logic signed [WAVE_WIDTH-1:0] s
  );
    logic signed [OUT_WIDTH-1:0] prod_i;
    logic signed [OUT_WIDTH-1:0] prod_q;
    prod_i = OUT_WIDTH'(li) * OUT_WIDTH'(c);
    prod_q = OUT_WIDTH'(lq) * OUT_WIDTH'(s);
    return prod_i - prod_q;
  endfunction

  logic [0:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [M-1:0]           sym_i;
  logic [M-1:0]           sym_q;
  logic [PHASE_WIDTH-1:0] phase;
  logic                   last;
  logic                   hs;

  assign last     = (cnt == CNT_LAST);
  assign in_ready = !reset && ((state == ST_IDLE) || last);
  assign hs       = in_valid && in_ready;

  // NCO accumulator runs every cycle so the carrier stays phase-continuous.
  always_ff @(posedge clk) begin
    if (reset) phase <= '0;
    else       phase <= phase + freq_word;
  end

  // Symbol FSM: hold each symbol SAMPLES_PER_SYM cycles, reload or starve at the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hs) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        default: begin
          if (last) begin
            if (hs) begin
              cnt <= '0;
            end else begin
              state    <= ST_IDLE;
              underrun <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Symbol capture on handshake.
  always_ff @(posedge clk) begin
    if (hs) begin
      sym_i <= data_in[BITS_PER_SYM-1 -: M];
      sym_q <= data_in[M-1:0];
    end
  end

  logic                          vld_p0, vld_p1, vld_p2;
  logic signed [M:0]             lvl_i_p0, lvl_q_p0, lvl_i_p1, lvl_q_p1;
  logic [LUT_ADDR_W-1:0]         addr_p0;
  logic signed [WAVE_WIDTH-1:0]  cos_p1, sin_p1;
  logic signed [OUT_WIDTH-1:0]   sample_p2;

  // S1 boundary: levels and carrier address.
  always_ff @(posedge clk) begin
    vld_p0   <= reset ? 1'b0 : (state == ST_RUN);
    lvl_i_p0 <= axis_level(sym_i);
    lvl_q_p0 <= axis_level(sym_q);
    addr_p0  <= phase[PHASE_WIDTH-1 -: LUT_ADDR_W];
  end

  // S2 boundary: carrier lookup.
  always_ff @(posedge clk) begin
    vld_p1   <= reset ? 1'b0 : vld_p0;
    cos_p1   <= COS_TBL[int'(addr_p0)*WAVE_WIDTH +: WAVE_WIDTH];
    sin_p1   <= SIN_TBL[int'(addr_p0)*WAVE_WIDTH +: WAVE_WIDTH];
    lvl_i_p1 <= lvl_i_p0;
    lvl_q_p1 <= lvl_q_p0;
  end

  // S3 boundary: mixed sample.
  always_ff @(posedge clk) begin
    vld_p2    <= reset ? 1'b0 : vld_p1;
    sample_p2 <= mix(lvl_i_p1, lvl_q_p1, cos_p1, sin_p1);
  end

  assign out_valid  = vld_p2;
  assign sample_out = vld_p2 ? sample_p2 : '0;

endmodule

// File: tb/tb_qam_mod_stream.sv
// Directed bench for qam_mod_stream (default parameters plus QPSK and 64-QAM instances).
module tb_qam_mod_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [15:0]        freq_word;
  logic               in_valid;
  logic [3:0]         data_in;
  logic               in_ready;
  logic               out_valid;
  logic signed [18:0] sample_out;
  logic               underrun;

  logic               v2, r2, ov2, ur2;
  logic [1:0]         d2;
  logic signed [17:0] s2;
  logic               v6, r6, ov6, ur6;
  logic [5:0]         d6;
  logic signed [19:0] s6;

  qam_mod_stream dut (
    .clk(clk), .reset(reset), .freq_word(freq_word), .in_valid(in_valid),
    .in_ready(in_ready), .data_in(data_in), .out_valid(out_valid),
    .sample_out(sample_out), .underrun(underrun)
  );

  qam_mod_stream #(.BITS_PER_SYM(2)) dut2 (
    .clk(clk), .reset(reset), .freq_word(freq_word), .in_valid(v2),
    .in_ready(r2), .data_in(d2), .out_valid(ov2),
    .sample_out(s2), .underrun(ur2)
  );

  qam_mod_stream #(.BITS_PER_SYM(6)) dut6 (
    .clk(clk), .reset(reset), .freq_word(freq_word), .in_valid(v6),
    .in_ready(r6), .data_in(d6), .out_valid(ov6),
    .sample_out(s6), .underrun(ur6)
  );

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  nunder = 0;
  bit  mon_en = 1'b0;
  bit  hs_seen = 1'b0;
  int  exp_q[$];

  typedef struct {
    logic [3:0] data;
    int         exp;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected sample for freq_word=0 (cos=32767, sin=0) from the I code.
  function automatic int exp4(input logic [3:0] d);
    int lv;
`ifdef QAM_MOD_GRAY_EN
    case (d[3:2])
      2'b00:   lv = -3;
      2'b01:   lv = -1;
      2'b11:   lv = 1;
      default: lv = 3;
    endcase
`else
    case (d[3:2])
      2'b00:   lv = -3;
      2'b01:   lv = -1;
      2'b10:   lv = 1;
      default: lv = 3;
    endcase
`endif
    return lv * 32767;
  endfunction

  // One clock; outputs are read 1 time unit after the rising edge.
  task automatic step();
    logic       hs;
    logic [3:0] d;
    hs = in_valid && in_ready;
    d  = data_in;
    @(posedge clk);
    #1;
    cyc++;
    hs_seen = hs;
    if (hs && mon_en) for (int j = 0; j < 4; j++) exp_q.push_back(exp4(d));
    if (underrun) nunder++;
    if (mon_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_valid", out_valid, 0);
        else chk("stream_sample", sample_out, exp_q.pop_front());
      end else begin
        chk("idle_sample_zero", sample_out, 0);
      end
    end
  endtask

  task automatic send_sym(input logic [3:0] d);
    int n;
    in_valid = 1'b1;
    data_in  = d;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("send_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  vec_t vecs[4];
  int   rot[4];
  int   smp[4];

  initial begin
    int sent, nv, first, lastv, prev, r;
    logic [3:0] rot_data;

`ifdef QAM_MOD_GRAY_EN
    vecs[0] = '{4'b1000,  98301};
    vecs[1] = '{4'b0000, -98301};
    vecs[2] = '{4'b1101,  32767};
    vecs[3] = '{4'b0110, -32767};
    rot_data = 4'b1110;
    d6 = 6'b100_000;
`else
    vecs[0] = '{4'b1100,  98301};
    vecs[1] = '{4'b0000, -98301};
    vecs[2] = '{4'b1001,  32767};
    vecs[3] = '{4'b0111, -32767};
    rot_data = 4'b1011;
    d6 = 6'b111_000;
`endif
    rot = '{32767, -98301, -32767, 98301};

    reset = 1'b1; freq_word = 16'h0; in_valid = 1'b0; data_in = 4'h0;
    v2 = 1'b0; d2 = 2'b10; v6 = 1'b0;

    // Reset state
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sample", sample_out, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    step();

    // Single symbols from the vector table
    for (int v = 0; v < 4; v++) begin
      nunder = 0;
      send_sym(vecs[v].data);
      chk("tbl_busy_ready", in_ready, 0);
      step(); step();
      for (int j = 0; j < 4; j++) begin
        step();
        chk("tbl_valid", out_valid, 1);
        chk("tbl_sample", sample_out, vecs[v].exp);
      end
      step();
      chk("tbl_end_valid", out_valid, 0);
      chk("tbl_end_sample", sample_out, 0);
      step();
      chk("tbl_underrun_count", nunder, 1);
    end

    // Back-to-back symbols 0..15
    mon_en = 1'b1; nunder = 0;
    in_valid = 1'b1; data_in = 4'h0;
    sent = 0; nv = 0; first = -1; lastv = -1; prev = -1;
    for (int n = 0; n < 90; n++) begin
      step();
      if (hs_seen) begin
        if (prev >= 0) chk("b2b_spacing", cyc - prev, 4);
        prev = cyc;
        sent++;
        if (sent < 16) data_in = 4'(sent);
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        nv++;
        if (first < 0) first = cyc;
        lastv = cyc;
      end
      if (underrun && sent < 16) chk("b2b_early_underrun", underrun, 0);
    end
    chk("b2b_sent", sent, 16);
    chk("b2b_valid_count", nv, 64);
    chk("b2b_contiguous", lastv - first + 1, 64);
    chk("b2b_underrun", nunder, 1);
    chk("b2b_queue_empty", exp_q.size(), 0);
    mon_en = 1'b0;

    // Parameter sweep: QPSK and 64-QAM
    chk("sweep_r2", r2, 1);
    chk("sweep_r6", r6, 1);
    v2 = 1'b1; v6 = 1'b1;
    step();
    v2 = 1'b0; v6 = 1'b0;
    step(); step();
    for (int j = 0; j < 4; j++) begin
      step();
      chk("qpsk_valid", ov2, 1);
      chk("qpsk_sample", s2, 32767);
      chk("qam64_valid", ov6, 1);
      chk("qam64_sample", s6, 229369);
    end
    step();
    chk("qpsk_end_valid", ov2, 0);
    chk("qam64_end_sample", s6, 0);
    step();

    // Reset in the middle of a symbol
    mon_en = 1'b1;
    send_sym(4'b1100);
    step(); step(); step(); step();
    reset = 1'b1;
    step();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_sample", sample_out, 0);
    chk("midrst_ready", in_ready, 0);
    exp_q.delete();
    reset = 1'b0;
    #1;
    chk("midrst_ready_after", in_ready, 1);
    nunder = 0; nv = 0;
    send_sym(4'b0000);
    for (int j = 0; j < 7; j++) begin
      step();
      if (out_valid) nv++;
    end
    chk("midrst_fresh_count", nv, 4);
    chk("midrst_queue_empty", exp_q.size(), 0);
    chk("midrst_underrun", nunder, 1);
    mon_en = 1'b0;

    // Quarter-rate carrier rotation, I=+1 Q=+3
    freq_word = 16'h4000;
    send_sym(rot_data);
    step(); step();
    for (int j = 0; j < 4; j++) begin
      step();
      chk("rot_valid", out_valid, 1);
      smp[j] = sample_out;
    end
    r = -1;
    for (int k = 0; k < 4; k++) if (smp[0] == rot[k]) r = k;
    chk("rot_first_in_set", (r >= 0) ? 1 : 0, 1);
    if (r < 0) r = 0;
    for (int j = 1; j < 4; j++) chk("rot_order", smp[j], rot[(r + j) % 4]);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
